// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Bundles the program stream, the instruction-memory write/address port and
// the CPU control lines that pass between a host (master) and prog_loader
// (slave).
//   start        host -> loader  one-cycle load request
//   in_valid/in_data/in_last/in_ready   program word stream
//   cpu_addr     CPU instruction address (used while the CPU runs)
//   mem_addr/mem_wdata/mem_we           instruction-memory port
//   cpu_reset_o  CPU reset, done = CPU running, error = overflow (sticky)
//   word_count   words written from the stream in the current/last load
// -----------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we;
    logic                  cpu_reset_o;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   word_count;

    modport master (
        output start, in_valid, in_data, in_last, cpu_addr,
        input  in_ready, mem_addr, mem_wdata, mem_we, cpu_reset_o, done,
               error, word_count
    );

    modport slave (
        input  start, in_valid, in_data, in_last, cpu_addr,
        output in_ready, mem_addr, mem_wdata, mem_we, cpu_reset_o, done,
               error, word_count
    );
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Streams a program into instruction memory while holding the CPU in reset,
// optionally zero-fills the rest of memory, waits RELEASE_DELAY cycles and
// then releases the CPU. While the CPU runs, the memory address follows the
// CPU; a start pulse in RUN reloads.
// Ports:
//   clk    single clock (loader, memory write port, CPU)
//   reset  synchronous, active-high
//   bus    prog_loader_if.slave (stream, memory port, CPU control, status)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ZERO_FILL     = 1,
    parameter int RELEASE_DELAY = 2
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_FILL,
        S_HOLD,
        S_RUN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   DEPTH_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [7:0]            DELAY_INIT  = 8'(RELEASE_DELAY);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] load_addr_reg, load_addr_next;
    logic [ADDR_WIDTH:0]   word_count_reg, word_count_next;
    logic                  error_reg, error_next;
    logic [7:0]            delay_reg, delay_next;
    logic                  in_ready_c;
    logic                  accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            load_addr_reg  <= '0;
            word_count_reg <= '0;
            error_reg      <= 1'b0;
            delay_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            load_addr_reg  <= load_addr_next;
            word_count_reg <= word_count_next;
            error_reg      <= error_next;
            delay_reg      <= delay_next;
        end
    end

    // Handshake is gated by reset so a word presented during the reset cycle
    // is neither accepted nor written: reset aborts a load immediately.
    assign in_ready_c = ((state_reg == S_LOAD) || (state_reg == S_DRAIN)) && !reset;
    assign accept     = bus.in_valid && in_ready_c;

    always_comb begin
        state_next      = state_reg;
        load_addr_next  = load_addr_reg;
        word_count_next = word_count_reg;
        error_next      = error_reg;
        delay_next      = delay_reg;

        case (state_reg)
            S_IDLE, S_RUN: begin
                if (bus.start) begin
                    state_next      = S_LOAD;
                    load_addr_next  = '0;
                    word_count_next = '0;
                    error_next      = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (word_count_reg != DEPTH_COUNT) begin
                        word_count_next = word_count_reg + COUNT_ONE;
                    end
                    if (bus.in_last) begin
                        if ((ZERO_FILL == 1) && (load_addr_reg != LAST_ADDR)) begin
                            // FILL starts at the address after the last word
                            state_next     = S_FILL;
                            load_addr_next = load_addr_reg + ADDR_ONE;
                        end else begin
                            state_next = S_HOLD;
                            delay_next = DELAY_INIT;
                        end
                    end else if (load_addr_reg == LAST_ADDR) begin
                        // Memory full but the stream continues: flag and
                        // swallow the rest without wrapping the address.
                        state_next = S_DRAIN;
                        error_next = 1'b1;
                    end else begin
                        load_addr_next = load_addr_reg + ADDR_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && bus.in_last) begin
                    state_next = S_HOLD;
                    delay_next = DELAY_INIT;
                end
            end
            S_FILL: begin
                if (load_addr_reg == LAST_ADDR) begin
                    state_next = S_HOLD;
                    delay_next = DELAY_INIT;
                end else begin
                    load_addr_next = load_addr_reg + ADDR_ONE;
                end
            end
            S_HOLD: begin
                // Counter is loaded on entry; the cycle that sees 1 is the
                // last HOLD cycle, giving exactly RELEASE_DELAY cycles.
                if (delay_reg <= 8'd1) begin
                    state_next = S_RUN;
                    delay_next = '0;
                end else begin
                    delay_next = delay_reg - 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.mem_addr    = (state_reg == S_RUN) ? bus.cpu_addr : load_addr_reg;
    assign bus.mem_wdata   = (state_reg == S_LOAD) ? bus.in_data : '0;
    assign bus.mem_we      = ((state_reg == S_LOAD) && accept) ||
                             ((state_reg == S_FILL) && !reset);
    assign bus.cpu_reset_o = (state_reg != S_RUN);
    assign bus.done        = (state_reg == S_RUN);
    assign bus.error       = error_reg;
    assign bus.word_count  = word_count_reg;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Streams a program into instruction memory over a valid/ready interface while holding the CPU in reset.
- Owns the instruction-memory address mux between loader and CPU, optionally zero-fills the unused memory, then releases the CPU after a programmable delay.
- Supports reloading while the CPU runs.
- Sits between a host/bench data source, the instruction memory and cpu_4bit. It replaces hand-sequenced prog_we/prog_enable/cpu_reset driving.

Parameters:
- DATA_WIDTH, 8: instruction word width.
- ADDR_WIDTH, 4: instruction memory address width. DEPTH = 2**ADDR_WIDTH.
- ZERO_FILL, 1: when 1, addresses after the last loaded word are written with 0 up to DEPTH-1.
- RELEASE_DELAY, 2: cycles (1..255) that cpu_reset_o stays high after loading/filling completes.

Ports:
- clk  input  1  single clock for loader, memory write port and CPU.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; begins a load from IDLE or RUN.
- in_valid  input  1  input word valid.
- in_data  input  DATA_WIDTH  instruction word.
- in_last  input  1  marks final word of program; qualified by in_valid.
- in_ready  output  1  loader accepts a word this cycle.
- cpu_addr  input  ADDR_WIDTH  instruction address from CPU.
- mem_addr  output  ADDR_WIDTH  address to instruction memory.
- mem_wdata  output  DATA_WIDTH  write data to instruction memory.
- mem_we  output  1  write enable to instruction memory; memory writes on the rising clk edge.
- cpu_reset_o  output  1  reset to CPU.
- done  output  1  high in RUN.
- error  output  1  sticky overflow flag; cleared by reset or start.
- word_count  output  ADDR_WIDTH+1  words written from the stream in the last/current load.

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high; ports named clk and reset.
- States: IDLE, LOAD, DRAIN, FILL, HOLD, RUN.

Reset:
- Enter IDLE.
- Outputs: cpu_reset_o=1, in_ready=0, mem_we=0, done=0, error=0, word_count=0.
- Internal state: load_addr=0, delay counter=0.
- Memory contents are not touched.
- Reset in any state, including mid-load, aborts immediately with these values.

Datapath (combinational outputs):
- mem_addr = cpu_addr in RUN, else load_addr.
- mem_wdata = in_data in LOAD, 0 in FILL.
- mem_we = in_valid & in_ready in LOAD; 1 in FILL; 0 otherwise.
- in_ready = 1 in LOAD and DRAIN, else 0.

State transitions:
- IDLE: start -> LOAD; clear word_count and error; load_addr=0.
- LOAD: each accepted word (in_valid & in_ready) is written to load_addr in that cycle; load_addr and word_count increment.
  - Accepted with in_last=1: go to FILL if ZERO_FILL=1 and load_addr<DEPTH-1, else HOLD.
  - Accepted at load_addr=DEPTH-1 with in_last=0: set error=1, go to DRAIN. load_addr does not wrap.
  - in_valid=0: stall, no write, no state change.
- DRAIN: accept and discard words, no writes; accepted in_last -> HOLD.
- FILL: write 0 to load_addr+1 .. DEPTH-1, one address per cycle; after writing DEPTH-1 -> HOLD.
- HOLD: cpu_reset_o=1. Load counter with RELEASE_DELAY on entry; decrement each cycle. After exactly RELEASE_DELAY cycles in HOLD -> RUN.
- RUN: cpu_reset_o=0, done=1, mem_addr follows cpu_addr.
  - start -> LOAD; cpu_reset_o=1 and done=0 from the next cycle; error/word_count cleared.
- start is ignored in LOAD, DRAIN, FILL and HOLD.
- cpu_reset_o is 1 in every state except RUN.
- word_count saturates at DEPTH and does not count drained words.

Test Plan:
- DEPTH=16, ZERO_FILL=1, RELEASE_DELAY=2, start, then 10 words 0x31..0x3A back-to-back with in_last on the 10th -> addresses 0..9 hold the words, 10..15 hold 0, word_count=10, cpu_reset_o falls 2 cycles after the write to address 15, done=1, error=0.
- Same stream with in_valid dropped every other cycle -> identical memory contents; no write on stalled cycles; in_ready stays 1.
- 18 words, in_last on the 18th -> addresses 0..15 hold the first 16 words, error=1, word_count=16, two words drained, no FILL, CPU released after delay.
- In RUN with cpu_addr=5 -> mem_addr=5, mem_we=0. Pulse start -> cpu_reset_o=1 next cycle; load 1 word 0xFF with in_last -> address 0 = 0xFF, addresses 1..15 = 0, CPU released.
- Assert reset after 4 of 10 words -> IDLE next cycle, cpu_reset_o=1, in_ready=0, word_count=0; addresses 0..3 keep the written data.
- ZERO_FILL=0, 3 words -> no writes after address 2, HOLD entered the cycle after the last write, word_count=3.
